step_run_ctrl: RTL and testbench

- Consumes debounced one-shot button pulses and gates the miniRISC core clock-enable for board bring-up.
- The pulses arrive from the slow-clock debounce stage.
- Two modes:
  - single-step: each step pulse issues exactly STEP_CYCLES enabled core cycles.
  - free-run: the core is enabled every cycle.
- Sits between the push-button debounce stage and the core's enable input. Also exports an issued-cycle count for the LED/seven-segment display.

---
 rtl/step_run_ctrl_if.sv | 31 +++
 rtl/step_run_ctrl.sv | 129 ++++++++++++
 tb/tb_step_run_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/step_run_ctrl_if.sv
// Bundle of the button, halt and core-control signals of step_run_ctrl.
//   pb_step, pb_mode : debounced one-shot button pulses (slow domain, async to clk)
//   halt_in          : core halt indication, synchronous to clk
//   cpu_en           : registered core clock-enable
//   mode_run         : 1 = free-run, 0 = single-step
//   busy             : step burst in progress
//   halted           : controller latched in the halted state
//   step_count       : saturating count of enabled core cycles
// master drives the inputs (board/bench side); slave is the controller.
interface step_run_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             pb_step;
    logic             pb_mode;
    logic             halt_in;
    logic             cpu_en;
    logic             mode_run;
    logic             busy;
    logic             halted;
    logic [CNT_W-1:0] step_count;

    modport master (
        output pb_step, pb_mode, halt_in,
        input  cpu_en, mode_run, busy, halted, step_count
    );

    modport slave (
        input  pb_step, pb_mode, halt_in,
        output cpu_en, mode_run, busy, halted, step_count
    );
endinterface

// File: rtl/step_run_ctrl.sv
// Step/run controller gating the miniRISC core clock-enable for board bring-up.
// A step pulse issues exactly STEP_CYCLES enabled core cycles; a mode pulse toggles
// free-run, where the core is enabled every cycle. A sampled halt_in locks the
// controller in a halted state until reset.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   ctrl : step_run_ctrl_if.slave (button pulses and halt in; enable/status/count out)
// All outputs are direct flop outputs; there is no combinational input-to-output path.
module step_run_ctrl #(
    parameter int unsigned STEP_CYCLES = 1,   // legal range 1..255
    parameter int unsigned CNT_W       = 16
) (
    input logic            clk,
    input logic            rst,
    step_run_ctrl_if.slave ctrl
);

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StRun,
        StHalted
    } state_e;

    localparam logic [7:0] BurstLoad = 8'(STEP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       burst_q, burst_d;
    logic [2:0]       step_sync_q;
    logic [2:0]       mode_sync_q;
    logic             evt_step;
    logic             evt_mode;
    logic             cpu_en_q;
    logic             mode_run_q;
    logic             busy_q;
    logic             halted_q;
    logic [CNT_W-1:0] step_count_q;

    // Bits [0..2] are s1, s2, s3. s1/s2 resolve metastability; the s2 rising edge
    // gives a single-cycle event per pulse regardless of the pulse length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_sync_q <= 3'b000;
            mode_sync_q <= 3'b000;
        end else begin
            step_sync_q <= {step_sync_q[1:0], ctrl.pb_step};
            mode_sync_q <= {mode_sync_q[1:0], ctrl.pb_mode};
        end
    end

    assign evt_step = step_sync_q[1] & ~step_sync_q[2];
    assign evt_mode = mode_sync_q[1] & ~mode_sync_q[2];

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        if (ctrl.halt_in) begin
            // Halt overrides every event, including a burst ending this cycle.
            state_d = StHalted;
        end else begin
            case (state_q)
                StIdle: begin
                    // Mode wins over a simultaneous step; the step is dropped.
                    if (evt_mode) begin
                        state_d = StRun;
                    end else if (evt_step) begin
                        state_d = StStep;
                        burst_d = BurstLoad;
                    end
                end
                StStep: begin
                    // Events during a burst are discarded, never queued.
                    if (burst_q == 8'd0) begin
                        state_d = StIdle;
                    end else begin
                        burst_d = burst_q - 8'd1;
                    end
                end
                StRun: begin
                    if (evt_mode) begin
                        state_d = StIdle;
                    end
                end
                StHalted: begin
                    state_d = StHalted;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            burst_q    <= 8'd0;
            cpu_en_q   <= 1'b0;
            mode_run_q <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            cpu_en_q   <= (state_d == StStep) || (state_d == StRun);
            mode_run_q <= (state_d == StRun);
            busy_q     <= (state_d == StStep);
            halted_q   <= (state_d == StHalted);
        end
    end

    // Counts edges where the enable was high; holds at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_count_q <= '0;
        end else if (cpu_en_q && (step_count_q != {CNT_W{1'b1}})) begin
            step_count_q <= step_count_q + CNT_W'(1);
        end
    end

    assign ctrl.cpu_en     = cpu_en_q;
    assign ctrl.mode_run   = mode_run_q;
    assign ctrl.busy       = busy_q;
    assign ctrl.halted     = halted_q;
    assign ctrl.step_count = step_count_q;

endmodule

// File: tb/tb_step_run_ctrl.sv
// Directed bench for step_run_ctrl. Three instances share one stimulus:
//   u1: STEP_CYCLES=1, CNT_W=16   u4: STEP_CYCLES=4, CNT_W=4   u8: STEP_CYCLES=8, CNT_W=4
// Each directed step checks only the instance it targets. Samples are taken 1 ns
// after the rising edge; "sample k" is the k-th edge after an input is raised.
module tb_step_run_ctrl;

    logic clk;
    logic rst;
    logic pb_step;
    logic pb_mode;
    logic halt_in;

    int passed;
    int total;
    int en1, en4, en8;
    int base;

    step_run_ctrl_if #(.CNT_W(16)) if1 ();
    step_run_ctrl_if #(.CNT_W(4))  if4 ();
    step_run_ctrl_if #(.CNT_W(4))  if8 ();

    assign if1.pb_step = pb_step;
    assign if1.pb_mode = pb_mode;
    assign if1.halt_in = halt_in;
    assign if4.pb_step = pb_step;
    assign if4.pb_mode = pb_mode;
    assign if4.halt_in = halt_in;
    assign if8.pb_step = pb_step;
    assign if8.pb_mode = pb_mode;
    assign if8.halt_in = halt_in;

    step_run_ctrl #(.STEP_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .ctrl(if1.slave));
    step_run_ctrl #(.STEP_CYCLES(4), .CNT_W(4))  u4 (.clk(clk), .rst(rst), .ctrl(if4.slave));
    step_run_ctrl #(.STEP_CYCLES(8), .CNT_W(4))  u8 (.clk(clk), .rst(rst), .ctrl(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent tally of enabled cycles, sampled mid-cycle.
    initial begin
        en1 = 0;
        en4 = 0;
        en8 = 0;
    end
    always @(negedge clk) begin
        if (if1.cpu_en) en1 <= en1 + 1;
        if (if4.cpu_en) en4 <= en4 + 1;
        if (if8.cpu_en) en8 <= en8 + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(1);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst     = 1'b1;
        pb_step = 1'b0;
        pb_mode = 1'b0;
        halt_in = 1'b0;

        // Reset state
        cyc(2);
        chk("rst_cpu_en",   int'(if1.cpu_en), 0);
        chk("rst_mode_run", int'(if1.mode_run), 0);
        chk("rst_busy",     int'(if4.busy), 0);
        chk("rst_halted",   int'(if8.halted), 0);
        chk("rst_count",    int'(if1.step_count), 0);
        rst = 1'b0;
        cyc(1);

        // Long step press, STEP_CYCLES=1: one enabled cycle at sample 3
        base = en1;
        pb_step = 1'b1;
        cyc(2);
        chk("s1_en_s2",   int'(if1.cpu_en), 0);
        cyc(1);
        chk("s1_en_s3",   int'(if1.cpu_en), 1);
        chk("s1_busy_s3", int'(if1.busy), 1);
        cyc(1);
        chk("s1_en_s4",   int'(if1.cpu_en), 0);
        chk("s1_busy_s4", int'(if1.busy), 0);
        cyc(36);
        pb_step = 1'b0;
        cyc(2);
        chk("s1_en_total", en1 - base, 1);
        chk("s1_count",    int'(if1.step_count), 1);

        // STEP_CYCLES=4, second pulse inside the burst is dropped
        do_reset();
        base = en4;
        pb_step = 1'b1;
        cyc(2);
        pb_step = 1'b0;
        cyc(2);
        pb_step = 1'b1;
        cyc(2);
        pb_step = 1'b0;
        cyc(14);
        chk("s4_drop_en",    en4 - base, 4);
        chk("s4_drop_count", int'(if4.step_count), 4);

        // STEP_CYCLES=4, pulses 10 cycles apart: two full bursts
        do_reset();
        base = en4;
        pb_step = 1'b1;
        cyc(3);
        chk("s4_busy_s3", int'(if4.busy), 1);
        pb_step = 1'b0;
        cyc(7);
        pb_step = 1'b1;
        cyc(3);
        pb_step = 1'b0;
        cyc(10);
        chk("s4_two_en",    en4 - base, 8);
        chk("s4_two_count", int'(if4.step_count), 8);
        chk("s4_two_busy",  int'(if4.busy), 0);

        // Free-run window of 100 cycles
        do_reset();
        pb_mode = 1'b1;
        cyc(2);
        pb_mode = 1'b0;
        cyc(1);
        chk("run_mode_on", int'(if1.mode_run), 1);
        chk("run_en_on",   int'(if1.cpu_en), 1);
        cyc(97);
        pb_mode = 1'b1;
        cyc(2);
        chk("run_en_s102", int'(if1.cpu_en), 1);
        pb_mode = 1'b0;
        cyc(1);
        chk("run_en_off",   int'(if1.cpu_en), 0);
        chk("run_mode_off", int'(if1.mode_run), 0);
        chk("run_count",    int'(if1.step_count), 100);

        // Simultaneous step and mode from idle: run, no burst
        do_reset();
        pb_step = 1'b1;
        pb_mode = 1'b1;
        cyc(2);
        pb_step = 1'b0;
        pb_mode = 1'b0;
        cyc(1);
        chk("sim_mode", int'(if4.mode_run), 1);
        chk("sim_busy", int'(if4.busy), 0);
        cyc(1);
        chk("sim_busy2", int'(if4.busy), 0);

        // Halt during run, then buttons are ignored until reset
        halt_in = 1'b1;
        cyc(1);
        halt_in = 1'b0;
        chk("halt_en",     int'(if1.cpu_en), 0);
        chk("halt_halted", int'(if1.halted), 1);
        chk("halt_mode",   int'(if1.mode_run), 0);
        base = en1;
        pb_step = 1'b1;
        cyc(3);
        pb_step = 1'b0;
        pb_mode = 1'b1;
        cyc(3);
        pb_mode = 1'b0;
        cyc(6);
        chk("halt_no_en",  en1 - base, 0);
        chk("halt_stays",  int'(if1.halted), 1);
        rst = 1'b1;
        #1;
        chk("halt_rst_clr", int'(if1.halted), 0);
        cyc(1);
        rst = 1'b0;
        cyc(1);

        // Asynchronous reset mid-burst, STEP_CYCLES=8
        pb_step = 1'b1;
        cyc(2);
        pb_step = 1'b0;
        cyc(4);
        chk("mid_count_pre", int'(if8.step_count), 3);
        chk("mid_busy_pre",  int'(if8.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_en_async",    int'(if8.cpu_en), 0);
        chk("mid_busy_async",  int'(if8.busy), 0);
        chk("mid_count_async", int'(if8.step_count), 0);
        #1;
        rst = 1'b0;
        cyc(3);
        chk("mid_en_after",   int'(if8.cpu_en), 0);
        chk("mid_busy_after", int'(if8.busy), 0);

        // CNT_W=4 saturation under free-run
        do_reset();
        pb_mode = 1'b1;
        cyc(2);
        pb_mode = 1'b0;
        cyc(15);
        chk("sat_s17", int'(if8.step_count), 14);
        cyc(1);
        chk("sat_s18", int'(if8.step_count), 15);
        cyc(10);
        chk("sat_hold", int'(if8.step_count), 15);
        chk("sat_en",   int'(if8.cpu_en), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
